ccc16_apb: RTL and testbench
============================

CCC16_APB -- requirements
Module: ccc16_apb

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose the following ports, listed as name, direction, width and meaning:
- PCLK, in, 1, clock, rising edge.
- PRESETn, in, 1, async active-low reset.
- PADDR, in, 16, APB byte address.
- PSEL, in, 1, APB select.
- PENABLE, in, 1, APB access phase.
- PWRITE, in, 1, 1 means write.
- PWDATA, in, 32, write data.
- PRDATA, out, 32, read data.
- PREADY, out, 1, tied 1 (zero wait states).
- IRQ, out, 1, interrupt, equals OR of MIS.
- ext_in, in, 1, asynchronous external input.
REQ-003 SHALL map registers as name, offset, width and access:
- PR, 0x000, 16, RW, prescaler.
- CCMP, 0x004, 16, RW, count compare value.
- CAP, 0x008, 16, RO, captured time.
- CTRL, 0x00C, 4, RW.
- CFG, 0x010, 10, RW.
- IM, 0xF00, 2, RW.
- MIS, 0xF04, 2, RO.
- RIS, 0xF08, 2, RO.
- IC, 0xF0C, 2, write-1-to-clear.
REQ-004 SHALL return 0 for reads of unmapped offsets and for unused register bits.

Function
REQ-005 SHALL perform a write when PSEL&PENABLE&PWRITE are all high, and SHALL drive PRDATA combinationally from PADDR.
REQ-006 SHALL decode CTRL bits as follows:
- [0] TE: timer/capture enable.
- [1] CE: edge-counter enable.
- [2] GFE: glitch filter enable.
- [3] CLR: writing 1 zeroes counter and timer; self-clearing, reads 0.
REQ-007 SHALL decode CFG bits as follows:
- [3:0] GFLEN: glitch filter length.
- [5:4] CNT_EV: counter event.
- [7:6] CAP_START: capture start event.
- [9:8] CAP_STOP: capture stop event.
REQ-008 SHALL encode every event field as 00 none, 01 rising edge, 10 falling edge, 11 either edge.
REQ-009 SHALL synchronize ext_in through two flops before any use.
REQ-010 Glitch filter, GFE=1: filtered signal SHALL adopt a new synchronized value only after it has been stable for max(GFLEN,1) consecutive PCLK cycles. GFE=0: filtered signal SHALL equal the synchronized input.
REQ-011 SHALL detect edges on the filtered signal as single-cycle pulses, delayed one cycle from the filtered-signal change.
REQ-012 Prescaler: an 16-bit down-counter SHALL produce a one-cycle tick every PR+1 PCLK cycles while TE=1. It SHALL reload when TE=0.
REQ-013 Edge counter (CE=1): the 16-bit count SHALL increment on each CNT_EV event. When the incremented value equals CCMP, RIS[0] (CM) SHALL set and the count SHALL return to 0 in the same cycle. CCMP=0 SHALL never match.
REQ-014 Timer/capture (TE=1) SHALL run as a two-state FSM:
- IDLE -> RUN on a CAP_START event; the 16-bit timer clears to 0.
- In RUN the timer SHALL increment on each tick, saturating at 0xFFFF.
- RUN -> IDLE on a CAP_STOP event; the timer value is latched into CAP and RIS[1] (CAPD) sets.
REQ-015 When a start and a stop event coincide in RUN, stop SHALL take priority. The next start is honoured on a later event.
REQ-016 Clearing TE or CE SHALL hold the corresponding counter and return the FSM to IDLE; CAP SHALL be retained.
REQ-017 RIS bits SHALL be sticky. An IC write-1 SHALL clear the bit, but a set event in the same cycle SHALL win.
REQ-018 MIS SHALL equal RIS&IM, and IRQ SHALL equal |MIS.

Reset
REQ-019 On PRESETn low, asynchronously:
- all registers, counters, prescaler, FSM (IDLE), RIS and CAP SHALL clear to 0;
- the synchronizer and filter state SHALL clear to 0;
- PRDATA SHALL read 0 and IRQ SHALL be 0.

Structure
REQ-020 A shared package SHALL hold register offsets, CTRL/CFG bit positions, event encodings and the FSM state enumeration.
REQ-021 The core SHALL be a sub-module aucohl_ccc16_core (filter, edge detect, prescaler, counter, capture FSM); the top SHALL hold the APB register file and interrupt logic.

Verification
REQ-022 Count match, stimulus:
- PR=4, CCMP=5, CFG=0x014 (rising, GFLEN=4), CTRL=0x6;
- ext_in square wave, 30.333 us low / 40.444 us high, PCLK 10 MHz; wait 500 us.
Required: RIS[0]=1.
REQ-023 High-pulse capture, stimulus: PR=4, CFG=0x244 (start rising, stop falling, GFLEN=4), CTRL=0x5, same waveform, wait 100 us. Required:
- RIS[1]=1;
- CAP within 80..81 (404 cycles /5).
REQ-024 Glitch rejection: GFE=1, GFLEN=8, 3-cycle ext_in pulses -> count stays 0 and RIS[0]=0. With GFE=0 the same pulses are counted.
REQ-025 Interrupts: IM=0x3 after CM -> IRQ=1 and MIS=0x1. Write IC=0x1 -> RIS[0]=0 and IRQ=0.
REQ-026 Reset mid-capture: assert PRESETn in RUN -> CAP=0, RIS=0, all registers read 0, IRQ=0.
REQ-027 CLR: write CTRL=0xE mid-count -> count restarts from 0, needs 5 further edges for CM, and CTRL[3] reads 0.

Source files
------------

// File: rtl/ccc16_pkg.sv
// rtl/ccc16_pkg.sv - register map, field positions, event encodings and FSM states for ccc16
package ccc16_pkg;

    localparam logic [15:0] OFF_PR   = 16'h000;
    localparam logic [15:0] OFF_CCMP = 16'h004;
    localparam logic [15:0] OFF_CAP  = 16'h008;
    localparam logic [15:0] OFF_CTRL = 16'h00C;
    localparam logic [15:0] OFF_CFG  = 16'h010;
    localparam logic [15:0] OFF_IM   = 16'hF00;
    localparam logic [15:0] OFF_MIS  = 16'hF04;
    localparam logic [15:0] OFF_RIS  = 16'hF08;
    localparam logic [15:0] OFF_IC   = 16'hF0C;

    localparam int CTRL_TE  = 0;
    localparam int CTRL_CE  = 1;
    localparam int CTRL_GFE = 2;
    localparam int CTRL_CLR = 3;

    localparam int CFG_GFLEN_LSB     = 0;
    localparam int CFG_CNT_EV_LSB    = 4;
    localparam int CFG_CAP_START_LSB = 6;
    localparam int CFG_CAP_STOP_LSB  = 8;

    localparam int RIS_CM   = 0;
    localparam int RIS_CAPD = 1;

    typedef enum logic [1:0] {
        EV_NONE = 2'b00,
        EV_RISE = 2'b01,
        EV_FALL = 2'b10,
        EV_BOTH = 2'b11
    } ev_sel_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cap_state_e;

    function automatic logic ev_hit(input logic [1:0] sel, input logic rise, input logic fall);
        return ((sel == EV_RISE || sel == EV_BOTH) && rise) ||
               ((sel == EV_FALL || sel == EV_BOTH) && fall);
    endfunction

endpackage

// File: rtl/aucohl_ccc16_core.sv
// rtl/aucohl_ccc16_core.sv - input conditioning, prescaler, edge counter and capture FSM
module aucohl_ccc16_core
    import ccc16_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ext_in,
    input  logic        te,
    input  logic        ce,
    input  logic        gfe,
    input  logic        clr,
    input  logic [15:0] pr,
    input  logic [15:0] ccmp,
    input  logic [3:0]  gflen,
    input  logic [1:0]  cnt_ev_sel,
    input  logic [1:0]  start_sel,
    input  logic [1:0]  stop_sel,
    output logic [15:0] cap,
    output logic        cm_set,
    output logic        capd_set
);

    logic        sync1, sync2, filt_q, filt_d, filtered, rise, fall;
    logic [3:0]  gcnt, glen;
    logic [15:0] psc, count, count_inc, timer;
    logic        tick, cnt_ev, start_ev, stop_ev;
    cap_state_e  state, state_nxt;

    assign glen     = (gflen == 4'd0) ? 4'd1 : gflen;
    assign filtered = gfe ? filt_q : sync2;

    // filt_q shadows the synchronized input while the filter is off so enabling it is glitch-free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            filt_q <= 1'b0;
            gcnt   <= 4'd0;
            filt_d <= 1'b0;
            rise   <= 1'b0;
            fall   <= 1'b0;
        end else begin
            sync1 <= ext_in;
            sync2 <= sync1;
            if (!gfe || sync2 == filt_q) begin
                filt_q <= sync2;
                gcnt   <= 4'd0;
            end else if ({1'b0, gcnt} + 5'd1 >= {1'b0, glen}) begin
                filt_q <= sync2;
                gcnt   <= 4'd0;
            end else begin
                gcnt <= gcnt + 4'd1;
            end
            filt_d <= filtered;
            rise   <= filtered & ~filt_d;
            fall   <= ~filtered & filt_d;
        end
    end

    assign cnt_ev   = ev_hit(cnt_ev_sel, rise, fall);
    assign start_ev = ev_hit(start_sel, rise, fall);
    assign stop_ev  = ev_hit(stop_sel, rise, fall);
    assign tick     = te && (psc == 16'd0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            psc <= 16'd0;
        else if (!te || psc == 16'd0)
            psc <= pr;
        else
            psc <= psc - 16'd1;
    end

    assign count_inc = count + 16'd1;
    assign cm_set    = ce && cnt_ev && (ccmp != 16'd0) && (count_inc == ccmp);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= 16'd0;
        else if (clr)
            count <= 16'd0;
        else if (ce && cnt_ev)
            count <= cm_set ? 16'd0 : count_inc;
    end

    // stop is evaluated before start in RUN, so a coincident start is simply dropped
    always_comb begin
        state_nxt = state;
        capd_set  = 1'b0;
        if (!te) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: if (start_ev) state_nxt = ST_RUN;
                ST_RUN: begin
                    if (stop_ev) begin
                        state_nxt = ST_IDLE;
                        capd_set  = 1'b1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timer <= 16'd0;
            cap   <= 16'd0;
        end else begin
            if (clr)
                timer <= 16'd0;
            else if (te && state == ST_IDLE && start_ev)
                timer <= 16'd0;
            else if (te && state == ST_RUN && !stop_ev && tick && timer != 16'hFFFF)
                timer <= timer + 16'd1;
            if (capd_set)
                cap <= timer;
        end
    end

endmodule

// File: rtl/ccc16_apb.sv
// rtl/ccc16_apb.sv - APB register file and interrupt logic around the ccc16 core
module ccc16_apb
    import ccc16_pkg::*;
(
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic [15:0] PADDR,
    input  logic        PSEL,
    input  logic        PENABLE,
    input  logic        PWRITE,
    input  logic [31:0] PWDATA,
    output logic [31:0] PRDATA,
    output logic        PREADY,
    output logic        IRQ,
    input  logic        ext_in
);

    logic [15:0] pr, ccmp, cap;
    logic [2:0]  ctrl;
    logic [9:0]  cfg;
    logic [1:0]  im, ris, mis, ris_set, ic_clr;
    logic        wr, clr, cm_set, capd_set;
    logic        unused_pwdata;

    assign PREADY        = 1'b1;
    assign wr            = PSEL & PENABLE & PWRITE;
    assign clr           = wr && (PADDR == OFF_CTRL) && PWDATA[CTRL_CLR];
    assign unused_pwdata = ^PWDATA[31:16];

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pr   <= 16'd0;
            ccmp <= 16'd0;
            ctrl <= 3'd0;
            cfg  <= 10'd0;
            im   <= 2'd0;
        end else if (wr) begin
            case (PADDR)
                OFF_PR:   pr   <= PWDATA[15:0];
                OFF_CCMP: ccmp <= PWDATA[15:0];
                OFF_CTRL: ctrl <= PWDATA[2:0];
                OFF_CFG:  cfg  <= PWDATA[9:0];
                OFF_IM:   im   <= PWDATA[1:0];
                default: ;
            endcase
        end
    end

    assign ris_set = {capd_set, cm_set};
    assign ic_clr  = (wr && PADDR == OFF_IC) ? PWDATA[1:0] : 2'b00;

    // a set arriving with an IC write wins because it is ORed in after the clear
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn)
            ris <= 2'd0;
        else
            ris <= (ris & ~ic_clr) | ris_set;
    end

    assign mis = ris & im;
    assign IRQ = |mis;

    always_comb begin
        PRDATA = 32'd0;
        case (PADDR)
            OFF_PR:   PRDATA = {16'd0, pr};
            OFF_CCMP: PRDATA = {16'd0, ccmp};
            OFF_CAP:  PRDATA = {16'd0, cap};
            OFF_CTRL: PRDATA = {29'd0, ctrl};
            OFF_CFG:  PRDATA = {22'd0, cfg};
            OFF_IM:   PRDATA = {30'd0, im};
            OFF_MIS:  PRDATA = {30'd0, mis};
            OFF_RIS:  PRDATA = {30'd0, ris};
            default:  PRDATA = 32'd0;
        endcase
    end

    aucohl_ccc16_core u_core (
        .clk        (PCLK),
        .rst_n      (PRESETn),
        .ext_in     (ext_in),
        .te         (ctrl[CTRL_TE]),
        .ce         (ctrl[CTRL_CE]),
        .gfe        (ctrl[CTRL_GFE]),
        .clr        (clr),
        .pr         (pr),
        .ccmp       (ccmp),
        .gflen      (cfg[CFG_GFLEN_LSB +: 4]),
        .cnt_ev_sel (cfg[CFG_CNT_EV_LSB +: 2]),
        .start_sel  (cfg[CFG_CAP_START_LSB +: 2]),
        .stop_sel   (cfg[CFG_CAP_STOP_LSB +: 2]),
        .cap        (cap),
        .cm_set     (cm_set),
        .capd_set   (capd_set)
    );

endmodule

// File: tb/tb_ccc16_apb.sv
// tb/tb_ccc16_apb.sv - directed self-checking bench for ccc16_apb
module tb_ccc16_apb;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic [15:0] PADDR = 16'd0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic        PWRITE = 1'b0;
    logic [31:0] PWDATA = 32'd0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        IRQ;
    logic        ext_in = 1'b0;

    int checks = 0;
    int failures = 0;

    localparam logic [15:0] OFFS [9] = '{16'h000, 16'h004, 16'h008, 16'h00C, 16'h010,
                                         16'hF00, 16'hF04, 16'hF08, 16'hF0C};

    ccc16_apb dut (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .PADDR   (PADDR),
        .PSEL    (PSEL),
        .PENABLE (PENABLE),
        .PWRITE  (PWRITE),
        .PWDATA  (PWDATA),
        .PRDATA  (PRDATA),
        .PREADY  (PREADY),
        .IRQ     (IRQ),
        .ext_in  (ext_in)
    );

    always #50 PCLK = ~PCLK;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    task automatic apb_write(input logic [15:0] a, input logic [31:0] d);
        @(posedge PCLK); #1;
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [15:0] a, output logic [31:0] d);
        @(posedge PCLK); #1;
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        d = PRDATA;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic pulse(input int hi, input int lo);
        @(posedge PCLK); #1 ext_in = 1'b1;
        repeat (hi) @(posedge PCLK);
        #1 ext_in = 1'b0;
        repeat (lo) @(posedge PCLK);
    endtask

    task automatic square(input int n);
        for (int i = 0; i < n; i++) begin
            ext_in = 1'b0;
            #30333;
            ext_in = 1'b1;
            #40444;
        end
        ext_in = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        repeat (3) @(posedge PCLK);
        #1;
        checks++;
        if (IRQ !== 1'b0) begin failures++; $display("FAIL reset_irq: got %0b want 0", IRQ); end
        checks++;
        if (PREADY !== 1'b1) begin failures++; $display("FAIL pready: got %0b want 1", PREADY); end
        PRESETn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            apb_read(OFFS[i], d);
            checks++;
            if (d !== 32'd0) begin failures++; $display("FAIL reset_reg_%h: got %h want 0", OFFS[i], d); end
        end
    endtask

    task automatic test_regs();
        logic [31:0] d;
        apb_write(16'h000, 32'hFFFF_A5A5);
        apb_write(16'h004, 32'h0000_1234);
        apb_write(16'h010, 32'hFFFF_FFFF);
        apb_write(16'h00C, 32'h0000_000F);
        apb_write(16'hF00, 32'h0000_00FF);
        apb_write(16'h008, 32'h0000_0055);
        apb_read(16'h000, d);
        checks++; if (d !== 32'h0000_A5A5) begin failures++; $display("FAIL reg_pr: got %h want 0000a5a5", d); end
        apb_read(16'h004, d);
        checks++; if (d !== 32'h0000_1234) begin failures++; $display("FAIL reg_ccmp: got %h want 00001234", d); end
        apb_read(16'h010, d);
        checks++; if (d !== 32'h0000_03FF) begin failures++; $display("FAIL reg_cfg: got %h want 000003ff", d); end
        apb_read(16'h00C, d);
        checks++; if (d !== 32'h0000_0007) begin failures++; $display("FAIL reg_ctrl: got %h want 00000007", d); end
        apb_read(16'hF00, d);
        checks++; if (d !== 32'h0000_0003) begin failures++; $display("FAIL reg_im: got %h want 00000003", d); end
        apb_read(16'h008, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reg_cap_ro: got %h want 0", d); end
        apb_read(16'h014, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL unmapped_014: got %h want 0", d); end
        apb_read(16'hF10, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL unmapped_f10: got %h want 0", d); end
        apb_write(16'h00C, 32'h0);
        apb_write(16'h000, 32'h0);
        apb_write(16'h004, 32'h0);
        apb_write(16'h010, 32'h0);
        apb_write(16'hF00, 32'h0);
    endtask

    task automatic test_count_match();
        logic [31:0] d;
        apb_write(16'h000, 32'd4);
        apb_write(16'h004, 32'd5);
        apb_write(16'h010, 32'h014);
        apb_write(16'h00C, 32'h6);
        square(4);
        repeat (50) @(posedge PCLK);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL cm_after_4_edges: got %h want 0", d); end
        square(3);
        repeat (50) @(posedge PCLK);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL cm_after_7_edges: got %h want 1", d); end
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL irq_masked: got %0b want 0", IRQ); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        apb_write(16'hF00, 32'h3);
        apb_read(16'hF04, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL mis_cm: got %h want 1", d); end
        checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL irq_set: got %0b want 1", IRQ); end
        apb_write(16'hF0C, 32'h1);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL ris_after_ic: got %h want 0", d); end
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL irq_after_ic: got %0b want 0", IRQ); end
    endtask

    task automatic test_clr();
        logic [31:0] d;
        pulse(20, 20);
        pulse(20, 20);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL clr_pre_count4: got %h want 0", d); end
        apb_write(16'h00C, 32'hE);
        apb_read(16'h00C, d);
        checks++; if (d !== 32'h6) begin failures++; $display("FAIL clr_selfclear: got %h want 6", d); end
        for (int i = 0; i < 4; i++) pulse(20, 20);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL clr_4_edges: got %h want 0", d); end
        pulse(20, 20);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL clr_5_edges: got %h want 1", d); end
        apb_write(16'hF0C, 32'h1);
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        apb_write(16'h004, 32'd3);
        apb_write(16'h010, 32'h018);
        apb_write(16'h00C, 32'h6);
        for (int i = 0; i < 3; i++) pulse(3, 20);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL glitch_rejected: got %h want 0", d); end
        apb_write(16'h00C, 32'h2);
        pulse(3, 20);
        pulse(3, 20);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL nofilter_2_pulses: got %h want 0", d); end
        pulse(3, 20);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL nofilter_3_pulses: got %h want 1", d); end
        apb_write(16'hF0C, 32'h1);
    endtask

    task automatic test_ccmp_zero();
        logic [31:0] d;
        apb_write(16'h004, 32'd0);
        for (int i = 0; i < 4; i++) pulse(3, 20);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL ccmp_zero: got %h want 0", d); end
        apb_write(16'h00C, 32'h0);
    endtask

    task automatic test_capture();
        logic [31:0] d;
        apb_write(16'hF0C, 32'h3);
        apb_write(16'h000, 32'd4);
        apb_write(16'h010, 32'h244);
        apb_write(16'h00C, 32'h5);
        square(1);
        repeat (300) @(posedge PCLK);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL capd_ris: got %h want 2", d); end
        apb_read(16'h008, d);
        checks++; if (d < 32'd80 || d > 32'd81) begin failures++; $display("FAIL cap_value: got %0d want 80..81", d); end
        apb_read(16'hF04, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL capd_mis: got %h want 2", d); end
        apb_write(16'h00C, 32'h0);
    endtask

    task automatic test_start_stop_priority();
        logic [31:0] d;
        apb_write(16'hF0C, 32'h3);
        apb_write(16'h000, 32'd0);
        apb_write(16'h010, 32'h3C1);
        apb_write(16'h00C, 32'h1);
        pulse(10, 20);
        apb_read(16'hF08, d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL prio_ris: got %h want 2", d); end
        apb_read(16'h008, d);
        checks++; if (d !== 32'd9) begin failures++; $display("FAIL prio_cap10: got %0d want 9", d); end
        apb_write(16'hF0C, 32'h2);
        pulse(5, 20);
        apb_read(16'h008, d);
        checks++; if (d !== 32'd4) begin failures++; $display("FAIL prio_cap5: got %0d want 4", d); end
        apb_write(16'h00C, 32'h0);
    endtask

    task automatic test_reset_mid_capture();
        logic [31:0] d;
        apb_write(16'hF0C, 32'h3);
        apb_write(16'h000, 32'd4);
        apb_write(16'h010, 32'h244);
        apb_write(16'h00C, 32'h5);
        pulse(10, 20);
        #1;
        checks++; if (IRQ !== 1'b1) begin failures++; $display("FAIL pre_reset_irq: got %0b want 1", IRQ); end
        @(posedge PCLK); #1 ext_in = 1'b1;
        repeat (40) @(posedge PCLK);
        #20 PRESETn = 1'b0;
        #10;
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL async_reset_irq: got %0b want 0", IRQ); end
        ext_in = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        for (int i = 0; i < 9; i++) begin
            apb_read(OFFS[i], d);
            checks++;
            if (d !== 32'd0) begin failures++; $display("FAIL midrun_reset_reg_%h: got %h want 0", OFFS[i], d); end
        end
        checks++; if (IRQ !== 1'b0) begin failures++; $display("FAIL post_reset_irq: got %0b want 0", IRQ); end
    endtask

    initial begin
        test_reset();
        test_regs();
        test_count_match();
        test_irq();
        test_clr();
        test_glitch();
        test_ccmp_zero();
        test_capture();
        test_start_stop_priority();
        test_reset_mid_capture();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
